// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared FSM state type and default sizing for the serial word feeder
package serial_feeder_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W = $clog2(DEPTH_DEF);
  localparam int CNT_W = $clog2(DEPTH_DEF + 1);
  localparam int BIT_W = $clog2(WIDTH_DEF);
endpackage

// File: rtl/word_fifo.sv
// word_fifo: small first-word-fall-through FIFO with occupancy count
module word_fifo
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: buffers parallel words and shifts them out gaplessly, one bit per clock
module serial_word_feeder
  import serial_feeder_pkg::*;
#(
  parameter int   WIDTH     = WIDTH_DEF,
  parameter int   DEPTH     = DEPTH_DEF,
  parameter logic IDLE_BIT  = 1'b0,
  parameter logic MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(WIDTH);
  state_t state, state_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n, rd_data, src;
  logic [CW-1:0] count;
  logic out_bit_n, out_valid_n, frame_start_n, full, empty, push, pop, last;
  assign wr_ready = !full;
  assign push = wr_valid && wr_ready;
  assign busy = state == SHIFT || count != '0;
  word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wr_data(wr_data),
    .rd_data(rd_data), .full(full), .empty(empty), .count(count)
  );
  // A word boundary is either idle or the cycle driving the last bit; loading there keeps the stream gapless
  always_comb begin
    last = state == IDLE || bit_cnt == BW'(WIDTH - 1);
    pop = last && !empty;
    state_n = pop ? SHIFT : last ? IDLE : SHIFT;
    src = pop ? rd_data : shreg;
    out_valid_n = pop || !last;
    out_bit_n = out_valid_n ? (MSB_FIRST ? src[WIDTH-1] : src[0]) : IDLE_BIT;
    shreg_n = MSB_FIRST ? {src[WIDTH-2:0], 1'b0} : {1'b0, src[WIDTH-1:1]};
    bit_cnt_n = last ? '0 : bit_cnt + 1'b1;
    frame_start_n = pop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      out_bit <= IDLE_BIT;
      out_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
      out_bit <= out_bit_n;
      out_valid <= out_valid_n;
      frame_start <= frame_start_n;
    end
  end
endmodule
